// File: rtl/mem_unloader.sv
// rtl/mem_unloader.sv - reads req_count words x req_len elements from memory and streams them out
//
// Purpose:
//   Accepts one readback request, then for every element issues a single
//   read (ISSUE), captures the one-cycle-latency read data (CAPTURE) and
//   presents it on the output stream until accepted (SEND). After the final
//   element a one-cycle done pulse is produced (DONE) before returning to IDLE.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_sel/req_addr/req_count/req_len  select, base word, word count, elements per word
//   mem_en/mem_wr/mem_sel/mem_addr/wrd_addr  memory read port (mem_wr tied low)
//   mem_rdata                    read data, valid one cycle after mem_en
//   out_valid/out_ready/out_data/out_last   element stream
//   busy, done                   status
//   abort, aborted               only with MEM_UNLOADER_ABORT_EN defined
//
// Configuration:
//   MEM_UNLOADER_ABORT_EN        adds abort input and aborted output

module mem_unloader #(
    parameter int DATA_WIDTH  = 4,
    parameter int MAX_ADDR_W  = 16,
    parameter int WORD_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_sel,
    input  logic [MAX_ADDR_W-1:0]  req_addr,
    input  logic [MAX_ADDR_W-1:0]  req_count,
    input  logic [WORD_ADDR_W-1:0] req_len,
    output logic                   mem_en,
    output logic                   mem_wr,
    output logic [2:0]             mem_sel,
    output logic [MAX_ADDR_W-1:0]  mem_addr,
    output logic [WORD_ADDR_W-1:0] wrd_addr,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    input  logic                   out_ready,
`ifdef MEM_UNLOADER_ABORT_EN
    input  logic                   abort,
    output logic                   aborted,
`endif
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [MAX_ADDR_W-1:0]  WORD_ONE = 1;
    localparam logic [WORD_ADDR_W-1:0] ELEM_ONE = 1;

    state_t                   state, state_nxt;
    logic [2:0]               lat_sel;
    logic [MAX_ADDR_W-1:0]    lat_addr;
    logic [MAX_ADDR_W-1:0]    lat_count;
    logic [WORD_ADDR_W-1:0]   lat_len;
    logic [MAX_ADDR_W-1:0]    word_cnt;
    logic [WORD_ADDR_W-1:0]   elem_cnt;
    logic                     elem_wrap;
    logic                     is_last;
    logic                     accept;
    logic                     abort_hit;
    logic                     out_valid_r;
    logic [DATA_WIDTH-1:0]    out_data_r;

    assign accept    = (state == IDLE) && req_valid;
    assign elem_wrap = (elem_cnt == lat_len - ELEM_ONE);
    assign is_last   = elem_wrap && (word_cnt == lat_count - WORD_ONE);

`ifdef MEM_UNLOADER_ABORT_EN
    logic aborted_r;
    assign abort_hit = abort && ((state == ISSUE) || (state == CAPTURE) || (state == SEND));
    assign aborted   = (state == DONE) && aborted_r;
`else
    assign abort_hit = 1'b0;
`endif

    assign mem_wr    = 1'b0;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        mem_en    = 1'b0;
        mem_sel   = 3'd0;
        mem_addr  = '0;
        wrd_addr  = '0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    // Empty transfers skip straight to the completion pulse.
                    if (req_count == '0 || req_len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_sel   = lat_sel;
                mem_addr  = lat_addr + word_cnt;
                wrd_addr  = elem_cnt;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = SEND;
            end
            SEND: begin
                out_last = is_last;
                if (out_ready) begin
                    state_nxt = is_last ? DONE : ISSUE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort_hit) begin
            state_nxt = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_sel     <= 3'd0;
            lat_addr    <= '0;
            lat_count   <= '0;
            lat_len     <= '0;
            word_cnt    <= '0;
            elem_cnt    <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
`ifdef MEM_UNLOADER_ABORT_EN
            aborted_r   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                lat_sel   <= req_sel;
                lat_addr  <= req_addr;
                lat_count <= req_count;
                lat_len   <= req_len;
                word_cnt  <= '0;
                elem_cnt  <= '0;
`ifdef MEM_UNLOADER_ABORT_EN
                aborted_r <= 1'b0;
`endif
            end
            if (state == CAPTURE) begin
                out_data_r  <= mem_rdata;
                out_valid_r <= 1'b1;
            end
            if (state == SEND && out_ready) begin
                out_valid_r <= 1'b0;
                if (elem_wrap) begin
                    elem_cnt <= '0;
                    word_cnt <= word_cnt + WORD_ONE;
                end else begin
                    elem_cnt <= elem_cnt + ELEM_ONE;
                end
            end
            // Abort overrides the capture so no stale element is left presented.
            if (abort_hit) begin
                out_valid_r <= 1'b0;
`ifdef MEM_UNLOADER_ABORT_EN
                aborted_r   <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_unloader.sv
// tb/tb_mem_unloader.sv - table-driven self-checking bench for mem_unloader
module tb_mem_unloader;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sel;
    logic [15:0] req_addr;
    logic [15:0] req_count;
    logic [9:0]  req_len;
    logic        mem_en;
    logic        mem_wr;
    logic [2:0]  mem_sel;
    logic [15:0] mem_addr;
    logic [9:0]  wrd_addr;
    logic [3:0]  mem_rdata;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef MEM_UNLOADER_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    int tests = 0;
    int fails = 0;

    mem_unloader dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_addr(req_addr), .req_count(req_count), .req_len(req_len),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .wrd_addr(wrd_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
`ifdef MEM_UNLOADER_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] mem_val(input logic [15:0] a, input logic [9:0] w);
        logic [31:0] t;
        t = 32'(w) + 32'd1 + 32'(a) * 32'd5;
        return t[3:0];
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_val(mem_addr, wrd_addr);
    end

    logic [3:0]  data_q[$];
    logic        last_q[$];
    logic [15:0] addr_q[$];
    logic [9:0]  wrd_q[$];
    logic [2:0]  sel_q[$];
    int          viol = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                data_q.push_back(out_data);
                last_q.push_back(out_last);
            end
            if (mem_en) begin
                addr_q.push_back(mem_addr);
                wrd_q.push_back(wrd_addr);
                sel_q.push_back(mem_sel);
            end else if (mem_sel != 3'd0 || mem_addr != 16'd0 || wrd_addr != 10'd0) begin
                viol++;
            end
            if (mem_wr) viol++;
            if (done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] addr;
        logic [15:0] count;
        logic [9:0]  len;
        int          exp_n;
        logic [3:0]  exp_first;
        logic [3:0]  exp_last;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[5];

    task automatic start_req(input logic [2:0] s, input logic [15:0] a,
                             input logic [15:0] c, input logic [9:0] l);
        req_sel   = s;
        req_addr  = a;
        req_count = c;
        req_len   = l;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            if (done) begin
                cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (cyc < 0) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int d0, a0, cyc, errs, w, e;
        logic [15:0] ea;
        string tag;
        tag = $sformatf("v%0d", idx);
        d0 = data_q.size();
        a0 = addr_q.size();
        out_ready = 1'b1;
        start_req(v.sel, v.addr, v.count, v.len);
        wait_done(tag, cyc);
        check({tag, "_cycles"}, 32'(cyc), 32'(v.exp_cycles));
        check({tag, "_nelem"}, 32'(data_q.size() - d0), 32'(v.exp_n));
        check({tag, "_nmem"}, 32'(addr_q.size() - a0), 32'(v.exp_n));
        if (v.exp_n > 0 && data_q.size() - d0 == v.exp_n && addr_q.size() - a0 == v.exp_n) begin
            check({tag, "_first"}, 32'(data_q[d0]), 32'(v.exp_first));
            check({tag, "_last"}, 32'(data_q[d0 + v.exp_n - 1]), 32'(v.exp_last));
            errs = 0;
            for (int k = 0; k < v.exp_n; k++) begin
                w  = k / int'(v.len);
                e  = k % int'(v.len);
                ea = v.addr + 16'(w);
                if (data_q[d0 + k] !== mem_val(ea, 10'(e))) errs++;
                if (last_q[d0 + k] !== (k == v.exp_n - 1)) errs++;
                if (addr_q[a0 + k] !== ea) errs++;
                if (wrd_q[a0 + k] !== 10'(e)) errs++;
                if (sel_q[a0 + k] !== v.sel) errs++;
            end
            check({tag, "_seq"}, 32'(errs), 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int cyc, d0, a0, dc;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_sel   = 3'd0;
        req_addr  = 16'd0;
        req_count = 16'd0;
        req_len   = 10'd0;
        out_ready = 1'b0;
`ifdef MEM_UNLOADER_ABORT_EN
        abort     = 1'b0;
`endif
        vecs[0] = '{3'd6, 16'h0000, 16'd1, 10'd4, 4, 4'h1, 4'h4, 13};
        vecs[1] = '{3'd3, 16'hFFFF, 16'd2, 10'd3, 6, 4'hC, 4'h3, 19};
        vecs[2] = '{3'd1, 16'h0005, 16'd0, 10'd3, 0, 4'h0, 4'h0, 1};
        vecs[3] = '{3'd2, 16'h000A, 16'd3, 10'd0, 0, 4'h0, 4'h0, 1};
        vecs[4] = '{3'd0, 16'h0007, 16'd3, 10'd1, 3, 4'h4, 4'hE, 10};

        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset while an element is being held in SEND.
        out_ready = 1'b0;
        start_req(3'd5, 16'h0003, 16'd1, 10'd2);
        cyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin cyc = c; break; end
            @(posedge clk);
            #1;
        end
        check("rs_reach_send", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rs_out_valid", {31'd0, out_valid}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_req_ready", {31'd0, req_ready}, 32'd1);
        check("rs_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dc = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("rs_no_done", 32'(done_cnt - dc), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Back-pressure: element held for 5 cycles, delivered once.
        d0 = data_q.size();
        out_ready = 1'b0;
        start_req(3'd4, 16'h0004, 16'd1, 10'd2);
        for (int c = 0; c < 20; c++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        a0 = addr_q.size();
        for (int c = 0; c < 5; c++) begin
            check("bp_data", 32'(out_data), 32'h5);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        check("bp_no_mem_en", 32'(addr_q.size() - a0), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        check("bp_one_elem", 32'(data_q.size() - d0), 32'd1);
        wait_done("bp", cyc);
        check("bp_total", 32'(data_q.size() - d0), 32'd2);
        if (data_q.size() - d0 == 2) begin
            check("bp_d0", 32'(data_q[d0]), 32'h5);
            check("bp_d1", 32'(data_q[d0 + 1]), 32'h6);
        end
        @(posedge clk);
        #1;

`ifdef MEM_UNLOADER_ABORT_EN
        // Abort during the second SEND with the element being accepted.
        d0 = data_q.size();
        out_ready = 1'b1;
        start_req(3'd2, 16'h0010, 16'd1, 10'd8);
        cyc = -1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && data_q.size() - d0 == 1) begin cyc = c; break; end
            @(posedge clk);
            #1;
        end
        check("ab_reach", 32'(cyc >= 0), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("ab_done", {31'd0, done}, 32'd1);
        check("ab_aborted", {31'd0, aborted}, 32'd1);
        check("ab_valid", {31'd0, out_valid}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("ab_count", 32'(data_q.size() - d0), 32'd2);
        check("ab_idle", {31'd0, req_ready}, 32'd1);
`endif

        check("mem_port_idle_zero", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_unloader.md
MEM_UNLOADER -- requirements
Module: mem_unloader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of one memory element.
REQ-002 SHALL have parameter MAX_ADDR_W, default 16, word address width on the memory port.
REQ-003 SHALL have parameter WORD_ADDR_W, default 10, element-in-word offset width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports req_valid input 1 and req_ready output 1 for the readback request handshake.
REQ-007 SHALL have ports req_sel input 3, req_addr input MAX_ADDR_W, req_count input MAX_ADDR_W (words) and req_len input WORD_ADDR_W (elements per word).
REQ-008 SHALL have memory-side outputs mem_en 1, mem_wr 1, mem_sel 3, mem_addr MAX_ADDR_W and wrd_addr WORD_ADDR_W, plus input mem_rdata DATA_WIDTH with one-cycle synchronous read latency.
REQ-009 SHALL have stream outputs out_valid 1, out_data DATA_WIDTH and out_last 1, and stream input out_ready 1.
REQ-010 SHALL have outputs busy 1 and done 1.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, CAPTURE, SEND and DONE.
REQ-012 In IDLE: req_ready=1; on req_valid&&req_ready, latch sel/addr/count/len, clear word and element counters, and go to ISSUE (or DONE if req_count==0 or req_len==0).
REQ-013 In ISSUE: mem_en=1, mem_wr=0, mem_sel=latched sel, mem_addr=base+word counter (mod 2^MAX_ADDR_W), wrd_addr=element counter; next state CAPTURE.
REQ-014 In CAPTURE: register mem_rdata into out_data, set out_valid=1 and go to SEND; out_valid SHALL first be high in the cycle after the second rising edge following the accepting edge.
REQ-015 In SEND: hold out_data/out_valid stable until out_ready=1; on the handshake edge drop out_valid and advance the element counter, wrapping to 0 at req_len-1 and incrementing the word counter.
REQ-016 Leaving SEND: go to DONE after the last element of the last word, else ISSUE.
REQ-017 out_last SHALL be 1 only while SEND presents the final element (word req_count-1, element req_len-1).
REQ-018 In DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE; req_valid outside IDLE SHALL be ignored.
REQ-020 mem_wr SHALL be 0 at all times; mem_en SHALL be 1 only in ISSUE; mem_sel, mem_addr and wrd_addr SHALL be 0 whenever mem_en=0.
REQ-021 Each element SHALL be read exactly once; throughput is one element per 3 cycles with out_ready held high.

Reset
REQ-022 While rst=0, state SHALL be IDLE and req_ready=1; all other outputs and counters SHALL be 0, independent of clk.
REQ-023 A reset asserted mid-transfer SHALL abort it with no done pulse; the first post-reset request SHALL start from its own req_addr.

Configuration
REQ-024 Macro MEM_UNLOADER_ABORT_EN SHALL, when defined, add input abort 1: abort=1 in ISSUE, CAPTURE or SEND forces DONE on the next edge, clears out_valid, and pulses done with output aborted 1 high in the same cycle.
REQ-025 Without MEM_UNLOADER_ABORT_EN, the ports abort and aborted SHALL not exist and a transfer SHALL run only to completion or reset.

Verification
REQ-026 Reset mid-SEND -> out_valid=0, busy=0 and req_ready=1 immediately; no done pulse.
REQ-027 req_sel=6, req_addr=0, req_count=1, req_len=4, memory holding 1,2,3,4, out_ready=1 -> out_data 1,2,3,4 at 3-cycle spacing, out_last on the 4th element, done one cycle later.
REQ-028 req_count=2, req_len=3, req_addr=2^MAX_ADDR_W-1 -> mem_addr sequence FFFF,FFFF,FFFF,0000,0000,0000 (default width), with wrd_addr 0,1,2 per word.
REQ-029 out_ready=0 for 5 cycles during SEND -> out_data stable, no new mem_en pulses, and the element is delivered once when out_ready rises.
REQ-030 req_count=0 -> no mem_en assertion; done is high in the second cycle after acceptance.
REQ-031 With MEM_UNLOADER_ABORT_EN defined, abort in the 2nd SEND of req_len=8 -> done=1 and aborted=1 on the next cycle, and exactly 2 elements are delivered.
